lfsr_checker: RTL and testbench

- Receive-side counterpart of the XNOR-feedback pseudo-random generator.
- Accepts the serial bit stream produced by that generator: one new bit per step, equal to the bit just shifted into its LSB.
- Self-synchronises to the stream, declares lock, then free-runs its own copy and counts mismatching bits.
- Used for on-chip self-test of the random source that drives obstacle spawning, and for checking the stream at the output pins.

---
 rtl/lfsr_checker_if.sv | 27 ++
 rtl/lfsr_checker.sv | 171 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_checker_if : stream input and status outputs of lfsr_checker  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface lfsr_checker_if #(
  parameter int ERR_W = 8
);
  logic             enable;
  logic             bit_valid;
  logic             bit_in;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state_out;

  modport master (
    output enable, bit_valid, bit_in,
    input  locked, err_pulse, err_count, state_out
  );

  modport slave (
    input  enable, bit_valid, bit_in,
    output locked, err_pulse, err_count, state_out
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr_checker : self-synchronising checker for the XNOR LFSR stream |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr_checker #(
  parameter int NUM_BITS    = 8,
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_checker_if.slave bus
);

  localparam int SEED_W  = $clog2(NUM_BITS + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [SEED_W-1:0]  c_SEED_LAST  = SEED_W'(NUM_BITS - 1);
  localparam logic [MATCH_W-1:0] c_MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
  localparam logic [MISS_W-1:0]  c_MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

  // Tap table shared with the generator; bit 1 is the LSB.
  function automatic logic [16:1] f_taps(input int n);
    logic [16:1] m;
    m = '0;
    case (n)
      3:       begin m[3] = 1'b1; m[2] = 1'b1; end
      4:       begin m[4] = 1'b1; m[3] = 1'b1; end
      5:       begin m[5] = 1'b1; m[3] = 1'b1; end
      6:       begin m[6] = 1'b1; m[5] = 1'b1; end
      7:       begin m[7] = 1'b1; m[6] = 1'b1; end
      9:       begin m[9] = 1'b1; m[5] = 1'b1; end
      10:      begin m[10] = 1'b1; m[7] = 1'b1; end
      11:      begin m[11] = 1'b1; m[9] = 1'b1; end
      12:      begin m[12] = 1'b1; m[6] = 1'b1; m[4] = 1'b1; m[1] = 1'b1; end
      13:      begin m[13] = 1'b1; m[4] = 1'b1; m[3] = 1'b1; m[1] = 1'b1; end
      14:      begin m[14] = 1'b1; m[5] = 1'b1; m[3] = 1'b1; m[1] = 1'b1; end
      15:      begin m[15] = 1'b1; m[14] = 1'b1; end
      16:      begin m[16] = 1'b1; m[15] = 1'b1; m[13] = 1'b1; m[4] = 1'b1; end
      default: begin m[8] = 1'b1; m[6] = 1'b1; m[5] = 1'b1; m[4] = 1'b1; end
    endcase
    return m;
  endfunction

  localparam logic [16:1] c_TAPS16 = f_taps(NUM_BITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEED   = 2'd1,
    S_CHECK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [NUM_BITS:1]   r_sreg,   w_sreg_nxt;
  logic [SEED_W-1:0]   r_seed,   w_seed_nxt;
  logic [MATCH_W-1:0]  r_match,  w_match_nxt;
  logic [MISS_W-1:0]   r_miss,   w_miss_nxt;
  logic                r_locked, w_locked_nxt;
  logic                r_err_pulse, w_err_pulse_nxt;
  logic [ERR_W-1:0]    r_err_cnt,   w_err_cnt_nxt;

  logic w_pred;
  logic w_lockup;

  assign w_pred   = ~^(r_sreg & c_TAPS16[NUM_BITS:1]);
  assign w_lockup = &r_sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_seed      <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_seed      <= w_seed_nxt;
      r_match     <= w_match_nxt;
      r_miss      <= w_miss_nxt;
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_seed_nxt      = r_seed;
    w_match_nxt     = r_match;
    w_miss_nxt      = r_miss;
    w_locked_nxt    = r_locked;
    w_err_pulse_nxt = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;

    if (!bus.enable) begin
      w_state_nxt   = S_IDLE;
      w_sreg_nxt    = '0;
      w_seed_nxt    = '0;
      w_match_nxt   = '0;
      w_miss_nxt    = '0;
      w_locked_nxt  = 1'b0;
      w_err_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SEED;
          w_seed_nxt  = '0;
        end
        S_SEED: if (bus.bit_valid) begin
          w_sreg_nxt = {r_sreg[NUM_BITS-1:1], bus.bit_in};
          if (r_seed == c_SEED_LAST) begin
            w_state_nxt = S_CHECK;
            w_match_nxt = '0;
          end else begin
            w_seed_nxt = r_seed + 1'b1;
          end
        end
        S_CHECK: if (bus.bit_valid) begin
          w_sreg_nxt = {r_sreg[NUM_BITS-1:1], bus.bit_in};
          // An all-ones register predicts a constant 1 forever; never trust it.
          if ((bus.bit_in == w_pred) && !w_lockup) begin
            if (r_match == c_MATCH_LAST) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
              w_miss_nxt   = '0;
              w_match_nxt  = '0;
            end else begin
              w_match_nxt = r_match + 1'b1;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        S_LOCKED: if (bus.bit_valid) begin
          w_sreg_nxt = {r_sreg[NUM_BITS-1:1], w_pred};
          if (bus.bit_in != w_pred) begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + 1'b1;
            if (r_miss == c_MISS_LAST) begin
              w_state_nxt  = S_SEED;
              w_seed_nxt   = '0;
              w_miss_nxt   = '0;
              w_locked_nxt = 1'b0;
            end else begin
              w_miss_nxt = r_miss + 1'b1;
            end
          end else begin
            w_miss_nxt = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_cnt;
  assign bus.state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lfsr_checker : directed scoreboard bench for lfsr_checker       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(8)) bus ();

  lfsr_checker #(
    .NUM_BITS   (8),
    .LOCK_THRESH(16),
    .LOSS_THRESH(4),
    .ERR_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic [7:0] ec;
  } exp_t;

  exp_t q_exp[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference generator: 8-bit XNOR LFSR, taps 8,6,5,4.
  logic [8:1] g;
  localparam logic [8:1] c_GEN_TAPS = 8'b1011_1000;

  task automatic gen(output logic b);
    b = ~^(g & c_GEN_TAPS);
    g = {g[7:1], b};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue its expected result, compare after the edge.
  task automatic step(input string tag, input logic v, input logic b, input exp_t e);
    exp_t got;
    exp_t want;
    bus.bit_valid = v;
    bus.bit_in    = b;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    got  = {bus.locked, bus.err_pulse, bus.err_count};
    want = q_exp.pop_front();
    chk(tag, 32'(got), 32'(want));
  endtask

  task automatic send(input string tag, input logic inv, input logic lk, input logic ep, input logic [7:0] ec);
    logic b;
    gen(b);
    step(tag, 1'b1, b ^ inv, '{lk, ep, ec});
  endtask

  task automatic restart();
    bus.enable    = 1'b0;
    bus.bit_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("disable_state", 32'(bus.state_out), 32'd0);
    chk("disable_cnt", 32'({bus.locked, bus.err_count}), 32'd0);
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    chk("seed_entry", 32'(bus.state_out), 32'd1);
  endtask

  initial begin
    logic [7:0] ec;
    int         nv;
    g             = 8'h55;
    bus.enable    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.state_out), 32'd0);
    chk("reset_outs", 32'({bus.locked, bus.err_pulse, bus.err_count}), 32'd0);
    rst = 1'b0;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_to_seed", 32'(bus.state_out), 32'd1);

    // Acquire: 8 seed bits + 16 matches, lock visible after the 24th
    for (int i = 1; i <= 24; i++) begin
      send("acquire", 1'b0, i >= 24, 1'b0, 8'd0);
      if (i == 8) chk("seed_to_check", 32'(bus.state_out), 32'd2);
    end
    chk("locked_state", 32'(bus.state_out), 32'd3);
    for (int i = 0; i < 1000; i++) send("clean_run", 1'b0, 1'b1, 1'b0, 8'd0);

    // Single corrupted bit
    send("single_err", 1'b1, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 30; i++) send("after_single", 1'b0, 1'b1, 1'b0, 8'd1);

    // Gap cycles hold everything
    step("gap_hold", 1'b0, 1'b1, '{1'b1, 1'b0, 8'd1});

    // Four consecutive errors force loss of lock
    for (int k = 1; k <= 4; k++) send("burst_err", 1'b1, k < 4, 1'b1, 8'(1 + k));
    chk("loss_state", 32'(bus.state_out), 32'd1);
    for (int i = 1; i <= 24; i++) send("reacquire", 1'b0, i >= 24, 1'b0, 8'd5);

    // Alternate errors: saturate, never lose lock
    ec = 8'd5;
    for (int i = 0; i < 600; i++) begin
      if (i % 2 == 0) begin
        if (ec != 8'hFF) ec = ec + 8'd1;
        send("alt_err", 1'b1, 1'b1, 1'b1, ec);
      end else begin
        send("alt_ok", 1'b0, 1'b1, 1'b0, ec);
      end
    end
    chk("saturated", 32'(bus.err_count), 32'hFF);

    // Constant-ones stream sticks in XNOR lock-up; never locks
    restart();
    for (int i = 0; i < 100; i++) step("lockup", 1'b1, 1'b1, '{1'b0, 1'b0, 8'd0});
    chk("lockup_state", 32'(bus.state_out), 32'd2);

    // Random bit_valid gaps during acquire and lock
    restart();
    nv = 0;
    for (int i = 0; i < 2000 && nv < 80; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        nv++;
        if (nv == 50)      send("rand_err", 1'b1, 1'b1, 1'b1, 8'd1);
        else               send("rand_bit", 1'b0, nv >= 24, 1'b0, (nv > 50) ? 8'd1 : 8'd0);
      end else begin
        step("rand_gap", 1'b0, 1'($urandom_range(0, 1)), '{nv >= 24, 1'b0, (nv >= 50) ? 8'd1 : 8'd0});
      end
    end
    chk("rand_count", 32'(nv), 32'd80);

    // Asynchronous reset mid-stream, checked between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(bus.state_out), 32'd0);
    chk("async_rst_outs", 32'({bus.locked, bus.err_count}), 32'd0);
    @(posedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
